// File: rtl/bist_ctrl_param.sv
// Built-in self-test controller: LFSR pattern source, MISR response compactor,
// golden-signature compare, transparent to func_in outside a test run.
module bist_ctrl_param #(
    parameter int unsigned         TPG_W        = 3,
    parameter int unsigned         RSP_W        = 2,
    parameter int unsigned         LFSR_W       = 4,
    parameter logic [LFSR_W-1:0]   LFSR_TAPS    = 4'b1100,
    parameter logic [LFSR_W-1:0]   LFSR_SEED    = 4'b0001,
    parameter int unsigned         MISR_W       = 8,
    parameter logic [MISR_W-1:0]   MISR_TAPS    = 8'b10111000,
    parameter logic [MISR_W-1:0]   GOLDEN_SIG   = 8'hA5,
    parameter int unsigned         N_PATTERNS   = 16,
    parameter int unsigned         RESET_CYCLES = 2,
    parameter int unsigned         CUT_LAT      = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              bist_start,
    input  logic [TPG_W-1:0]  func_in,
    input  logic [RSP_W-1:0]  cut_out,
    output logic [TPG_W-1:0]  cut_in,
    output logic              cut_rst,
    output logic              bist_active,
    output logic              bist_end,
    output logic              pass_fail,
    output logic [MISR_W-1:0] signature
);

    localparam int unsigned SPAN    = N_PATTERNS + CUT_LAT;
    localparam int unsigned CNT_MAX = (RESET_CYCLES > SPAN) ? RESET_CYCLES : SPAN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // The counter runs continuously through RUN and FLUSH so capture is a single threshold.
    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(N_PATTERNS - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(SPAN - 1);
    localparam logic [CNT_W-1:0] CAP_FIRST  = CNT_W'(CUT_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_FLUSH,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_n, lfsr_step;
    logic [MISR_W-1:0]   misr_q, misr_n, misr_step;
    logic                pass_q, pass_n;
    logic                start_q;
    logic                start_pulse;
    logic                active_q, end_q, rst_q;

    assign start_pulse = bist_start & ~start_q;
    assign lfsr_step   = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    assign misr_step   = {misr_q[MISR_W-2:0], ^(misr_q & MISR_TAPS)} ^ MISR_W'(cut_out);

    // Next-state and datapath update
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        lfsr_n  = lfsr_q;
        misr_n  = misr_q;
        pass_n  = pass_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_pulse) begin
                    state_n = S_INIT;
                    cnt_n   = '0;
                    lfsr_n  = LFSR_SEED;
                    misr_n  = '0;
                    pass_n  = 1'b0;
                end
            end
            S_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (cnt_q >= CAP_FIRST) begin
                    misr_n = misr_step;
                end
                // Last pattern stays on cut_in through FLUSH, so the LFSR stops here.
                if (cnt_q == RUN_LAST) begin
                    state_n = (CUT_LAT == 0) ? S_COMPARE : S_FLUSH;
                end else begin
                    lfsr_n = lfsr_step;
                end
                cnt_n = cnt_q + 1'b1;
            end
            S_FLUSH: begin
                if (cnt_q >= CAP_FIRST) begin
                    misr_n = misr_step;
                end
                if (cnt_q == FLUSH_LAST) begin
                    state_n = S_COMPARE;
                end
                cnt_n = cnt_q + 1'b1;
            end
            S_COMPARE: begin
                pass_n  = (misr_q == GOLDEN_SIG);
                state_n = S_DONE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status flags
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            misr_q   <= '0;
            pass_q   <= 1'b0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
            end_q    <= 1'b0;
            rst_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            lfsr_q   <= lfsr_n;
            misr_q   <= misr_n;
            pass_q   <= pass_n;
            start_q  <= bist_start;
            active_q <= (state_n != S_IDLE) && (state_n != S_DONE);
            end_q    <= (state_n == S_DONE);
            rst_q    <= (state_n == S_INIT);
        end
    end

    assign cut_in      = ((state_q == S_IDLE) || (state_q == S_DONE)) ? func_in : lfsr_q[TPG_W-1:0];
    assign cut_rst     = rst_q;
    assign bist_active = active_q;
    assign bist_end    = end_q;
    assign pass_fail   = pass_q;
    assign signature   = misr_q;

endmodule

// File: doc/bist_ctrl_param.md
# bist_ctrl_param

Parametrised built-in self-test controller that wraps a circuit under test (CUT). It generates pseudo-random stimulus with an LFSR and compacts the CUT responses in a MISR. It then compares the final signature against a golden value and reports pass/fail. It sits between the top-level functional inputs and the CUT: in functional mode it is transparent, and during a test it owns the CUT inputs and the CUT reset. Width, pattern count, CUT latency and polynomials are all parameters, and the test can be re-triggered without a system reset.

## Interface
- TPG_W, 3: number of CUT inputs driven by the test pattern generator.
- RSP_W, 2: number of CUT outputs compacted.
- LFSR_W, 4: LFSR width, must be ≥ TPG_W.
- LFSR_TAPS, 4'b1100: feedback tap mask.
- LFSR_SEED, 4'b0001: LFSR start value, nonzero.
- MISR_W, 8: MISR width, must be ≥ RSP_W.
- MISR_TAPS, 8'b10111000: MISR feedback tap mask.
- GOLDEN_SIG, 8'hA5: expected final signature.
- N_PATTERNS, 16: patterns applied per run, ≥ 1.
- RESET_CYCLES, 2: CUT reset cycles before the patterns start, ≥ 1.
- CUT_LAT, 1: CUT input-to-output latency in cycles, ≥ 0.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- bist_start  in  1  a rising edge requests a test run.
- func_in  in  TPG_W  functional CUT inputs.
- cut_out  in  RSP_W  CUT responses.
- cut_in  out  TPG_W  muxed CUT inputs: func_in when idle, LFSR bits during a test.
- cut_rst  out  1  active-high CUT reset, asserted in INIT.
- bist_active  out  1  high from INIT through COMPARE.
- bist_end  out  1  high while in DONE.
- pass_fail  out  1  1 = signature matched; valid while bist_end is high.
- signature  out  MISR_W  current MISR contents.

## Operation
- **Start detection:** bist_start is registered (start_q). start_pulse = bist_start & ~start_q. The pulse is acted on only in IDLE or DONE and is ignored in every other state. Holding bist_start high never re-triggers a run.
- **FSM states:** IDLE, INIT, RUN, FLUSH, COMPARE, DONE.
- **IDLE:**
  - cut_in = func_in, cut_rst = 0.
  - On start_pulse: go to INIT, load LFSR ← LFSR_SEED, clear MISR ← 0, clear the counter, clear pass_fail.
- **INIT:** cut_rst = 1, cut_in = LFSR bits. Lasts RESET_CYCLES cycles, then RUN.
- **RUN:**
  - cut_in = lfsr[TPG_W-1:0].
  - LFSR advances every cycle: lfsr ← {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}.
  - Lasts N_PATTERNS cycles, then FLUSH. If CUT_LAT = 0, go directly to COMPARE.
- **FLUSH:** LFSR frozen, cut_in holds the last pattern. Lasts CUT_LAT cycles, then COMPARE.
- **MISR capture:**
  - Update rule: misr ← {misr[MISR_W-2:0], ^(misr & MISR_TAPS)} ^ zero-extended cut_out.
  - Captures on exactly N_PATTERNS edges: from the edge ending RUN cycle CUT_LAT+1 up to the edge ending the last FLUSH cycle.
  - Each captured response therefore corresponds to one applied pattern.
- **COMPARE:** one cycle. pass_fail ← (misr == GOLDEN_SIG), then DONE.
- **DONE:** bist_end = 1, pass_fail and signature hold, cut_in = func_in. On start_pulse: same actions as in IDLE, go to INIT.
- **Reset values:** state IDLE, LFSR = LFSR_SEED, MISR = 0, counter 0, start_q 0, pass_fail 0.
- **Output values at reset:** bist_end 0, bist_active 0, cut_rst 0, signature 0, cut_in = func_in.
- **Reset mid-test:** all state returns to IDLE immediately, asynchronously. No partial result is reported. A new edge on bist_start is required to start again.

## Timing
- Define P0 as the edge that samples start_pulse.
- INIT: P0 to P0+RESET_CYCLES.
- RUN: P0+R to P0+R+N.
- FLUSH: P0+R+N to P0+R+N+L.
- COMPARE: the cycle after P0+R+N+L.
- bist_end and pass_fail are valid after edge P0+R+N+L+1. With default parameters this is P0+20.
- bist_active and cut_rst are registered state decodes; they assert after P0.
- cut_in switches combinationally on state.

## Test plan
- **Reset:** assert RST_N=0 mid-cycle → all outputs at their reset values with no clock edge. cut_in tracks func_in=3'b101.
- **LFSR sequence:** defaults, start pulse, observe cut_in in RUN → low 3 bits of 0001, 0010, 0100, 1001, 0011, 0110, …; cut_rst high for exactly 2 cycles beforehand.
- **Golden pass:** behavioural CUT model whose signature equals GOLDEN_SIG → bist_end at P0+20, pass_fail=1, signature=8'hA5.
- **Fault detect:** cut_out stuck at 2'b00 → signature=8'h00, pass_fail=0, bist_end at P0+20.
- **Re-trigger:** bist_start held high for 3 cycles and released → exactly one run. A second pulse in DONE → bist_end drops and a new run starts with the MISR cleared. A pulse during RUN is ignored.
- **Reset mid-RUN:** RST_N low during pattern 7 → IDLE, bist_end=0, pass_fail=0. After release, no run starts until a new bist_start edge.
